// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), position width and sync-level helper.
// Imported by the timing generator and the colour-pattern stage.
package vga_pkg;
  localparam int POS_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-clock divider: tick is high on every CLK_DIV-th clk, combinational from divider state.
// Free-running after reset; no backpressure.
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_pix_tick: CLK_DIV must be in 1..16");
  end

  logic [DW-1:0] div_q, div_d;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters advance once per pixel tick; outputs registered, 1 clk behind counters.
// Free-running after reset; no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             pix_tick,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end

  logic tick;

  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [POS_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             started_q, started_d;
  logic             upd_q;
  logic             hsync_q, vsync_q, active_q, pix_tick_q, frame_start_q;
  logic [POS_W-1:0] x_q, y_q;
  logic             h_wrap, v_wrap, act_d, hs_in, vs_in;

  assign h_wrap = (h_cnt_q == POS_W'(H_TOTAL - 1));
  assign v_wrap = (v_cnt_q == POS_W'(V_TOTAL - 1));

  // The first tick after reset presents (0,0) rather than advancing past it.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    started_d = started_q;
    if (tick) begin
      if (!started_q) begin
        started_d = 1'b1;
      end else if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + POS_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + POS_W'(1);
      end
    end
  end

  assign act_d = (h_cnt_q < POS_W'(H_ACTIVE)) && (v_cnt_q < POS_W'(V_ACTIVE));
  assign hs_in = (h_cnt_q >= POS_W'(HS_BEG)) && (h_cnt_q < POS_W'(HS_END));
  assign vs_in = (v_cnt_q >= POS_W'(VS_BEG)) && (v_cnt_q < POS_W'(VS_END));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      started_q     <= 1'b0;
      upd_q         <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      started_q     <= started_d;
      upd_q         <= tick;
      pix_tick_q    <= upd_q;
      frame_start_q <= upd_q && (h_cnt_q == '0) && (v_cnt_q == '0);
      if (upd_q) begin
        active_q <= act_d;
        x_q      <= act_d ? h_cnt_q : '0;
        y_q      <= act_d ? v_cnt_q : '0;
        hsync_q  <= sync_level(hs_in, SYNC_POL);
        vsync_q  <= sync_level(vs_in, SYNC_POL);
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, reduced frame, CLK_DIV=1 with SYNC_POL=1)
// checked against an arithmetic pixel-index reference model.
module tb_vga_timing_gen;
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       fs;
  } obs_t;

  typedef struct {
    int d; int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit pol;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic hs_a, vs_a, act_a, pt_a, fs_a;
  logic hs_b, vs_b, act_b, pt_b, fs_b;
  logic hs_c, vs_c, act_c, pt_c, fs_c;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  obs_t oa, ob, oc;
  int ea = 0, eb = 0, ec = 0;
  int checks = 0;
  int errors = 0;
  cfg_t ca, cb, cc;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .x(x_a), .y(y_a), .pix_tick(pt_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .x(x_b), .y(y_b), .pix_tick(pt_b), .frame_start(fs_b)
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .hsync(hs_c), .vsync(vs_c), .active(act_c),
    .x(x_c), .y(y_c), .pix_tick(pt_c), .frame_start(fs_c)
  );

  assign oa = {hs_a, vs_a, act_a, x_a, y_a, pt_a, fs_a};
  assign ob = {hs_b, vs_b, act_b, x_b, y_b, pt_b, fs_b};
  assign oc = {hs_c, vs_c, act_c, x_c, y_c, pt_c, fs_c};

  // Rising edges seen since each reset was released.
  always @(posedge clk or negedge rst_a) if (!rst_a) ea <= 0; else ea <= ea + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) eb <= 0; else eb <= eb + 1;
  always @(posedge clk or negedge rst_c) if (!rst_c) ec <= 0; else ec <= ec + 1;

  // Pixel p is on the outputs from edge d*(p+1)+1 through edge d*(p+2).
  function automatic obs_t model(input int e, input cfg_t c);
    obs_t o;
    int p, h, v, ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    o = '0;
    o.hs = ~c.pol;
    o.vs = ~c.pol;
    if (e > c.d) begin
      p = (e - 1) / c.d - 1;
      h = p % ht;
      v = (p / ht) % vt;
      o.act = (h < c.ha) && (v < c.va);
      if (o.act) begin
        o.x = 10'(h);
        o.y = 10'(v);
      end
      o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
      o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
      o.pt = ((e - 1) % c.d) == 0;
      o.fs = o.pt && (h == 0) && (v == 0);
    end
    return o;
  endfunction

  task automatic test_reset();
    obs_t ra, rb, rc;
    ra = model(0, ca);
    rb = model(0, cb);
    rc = model(0, cc);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++; if (oa !== ra) begin errors++; $display("FAIL reset_a got=%h exp=%h", oa, ra); end
      checks++; if (ob !== rb) begin errors++; $display("FAIL reset_b got=%h exp=%h", ob, rb); end
      checks++; if (oc !== rc) begin errors++; $display("FAIL reset_c got=%h exp=%h", oc, rc); end
      checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++; $display("FAIL reset_sync_a got=%b exp=11", {hs_a, vs_a}); end
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  task automatic test_line();
    obs_t ex;
    int hs_lo_clks, hs_lo_ticks, act_ticks, x_bad, fall1, fall2;
    bit prev_hs;
    hs_lo_clks = 0; hs_lo_ticks = 0; act_ticks = 0; x_bad = 0;
    fall1 = -1; fall2 = -1; prev_hs = 1'b1;
    for (int n = 0; n < 6440; n++) begin
      @(negedge clk);
      ex = model(ea, ca);
      checks++; if (oa !== ex) begin errors++; $display("FAIL line_a e=%0d got=%h exp=%h", ea, oa, ex); end
      if (ea >= 5 && ea <= 3204) begin
        if (!hs_a) hs_lo_clks++;
        if (!hs_a && pt_a) hs_lo_ticks++;
        if (act_a && pt_a) begin
          if (x_a != 10'(act_ticks)) x_bad++;
          act_ticks++;
        end
      end
      if (prev_hs && !hs_a) begin
        if (fall1 < 0) fall1 = ea;
        else if (fall2 < 0) fall2 = ea;
      end
      prev_hs = hs_a;
    end
    checks++; if (hs_lo_ticks != 96) begin errors++; $display("FAIL hsync_low_ticks got=%0d exp=96", hs_lo_ticks); end
    checks++; if (hs_lo_clks != 384) begin errors++; $display("FAIL hsync_low_clks got=%0d exp=384", hs_lo_clks); end
    checks++; if (act_ticks != 640) begin errors++; $display("FAIL active_ticks got=%0d exp=640", act_ticks); end
    checks++; if (x_bad != 0) begin errors++; $display("FAIL x_sequence bad=%0d exp=0", x_bad); end
    checks++; if (fall2 - fall1 != 3200) begin errors++; $display("FAIL line_period got=%0d exp=3200", fall2 - fall1); end
  endtask

  task automatic test_frames();
    obs_t ex;
    int nfs, cyc, ticks, acts, vss, corners;
    bit corner_prev;
    nfs = 0; cyc = 0; ticks = 0; acts = 0; vss = 0; corners = 0; corner_prev = 1'b0;
    for (int n = 0; n < 1000 && nfs < 3; n++) begin
      @(negedge clk);
      ex = model(eb, cb);
      checks++; if (ob !== ex) begin errors++; $display("FAIL frame_b e=%0d got=%h exp=%h", eb, ob, ex); end
      if (fs_b) begin
        if (nfs > 0) begin
          checks++; if (cyc != 300) begin errors++; $display("FAIL frame_clks got=%0d exp=300", cyc); end
          checks++; if (ticks != 150) begin errors++; $display("FAIL frame_ticks got=%0d exp=150", ticks); end
          checks++; if (acts != 48) begin errors++; $display("FAIL frame_active got=%0d exp=48", acts); end
          checks++; if (vss != 30) begin errors++; $display("FAIL vsync_ticks got=%0d exp=30", vss); end
        end
        nfs++; cyc = 0; ticks = 0; acts = 0; vss = 0;
      end
      cyc++;
      if (pt_b) begin
        ticks++;
        if (act_b) acts++;
        if (!vs_b) vss++;
        if (corner_prev) begin
          corners++;
          checks++;
          if ({act_b, x_b, y_b} !== 21'd0) begin
            errors++; $display("FAIL frame_end got act=%b x=%0d y=%0d exp 0/0/0", act_b, x_b, y_b);
          end
        end
        corner_prev = act_b && (x_b == 10'(cb.ha - 1)) && (y_b == 10'(cb.va - 1));
      end
    end
    checks++; if (nfs != 3) begin errors++; $display("FAIL frame_starts_seen got=%0d exp=3", nfs); end
    checks++; if (corners < 2) begin errors++; $display("FAIL corner_hits got=%0d exp>=2", corners); end
  endtask

  task automatic test_mid_reset();
    obs_t ex, rb, ra;
    rb = model(0, cb);
    ra = model(0, ca);
    for (int it = 0; it < 5; it++) begin
      repeat ($urandom_range(20, 300)) @(negedge clk);
      rst_b = 1'b0;
      #1;
      checks++; if (ob !== rb) begin errors++; $display("FAIL midrst_b_now got=%h exp=%h", ob, rb); end
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        checks++; if (ob !== rb) begin errors++; $display("FAIL midrst_b_hold got=%h exp=%h", ob, rb); end
      end
      rst_b = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        ex = model(eb, cb);
        checks++; if (ob !== ex) begin errors++; $display("FAIL midrst_b e=%0d got=%h exp=%h", eb, ob, ex); end
        checks++; if (fs_b !== (k == cb.d + 1)) begin errors++; $display("FAIL midrst_b_fs k=%0d got=%b", k, fs_b); end
      end
    end
    for (int n = 0; n < 4000; n++) begin
      if (act_a && x_a == 10'd300) break;
      @(negedge clk);
    end
    checks++; if (!(act_a && x_a == 10'd300)) begin errors++; $display("FAIL midrst_a_reach x=%0d exp=300", x_a); end
    rst_a = 1'b0;
    #1;
    checks++; if (oa !== ra) begin errors++; $display("FAIL midrst_a_now got=%h exp=%h", oa, ra); end
    @(negedge clk);
    checks++; if (oa !== ra) begin errors++; $display("FAIL midrst_a_hold got=%h exp=%h", oa, ra); end
    rst_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ex = model(ea, ca);
      checks++; if (oa !== ex) begin errors++; $display("FAIL midrst_a e=%0d got=%h exp=%h", ea, oa, ex); end
      checks++; if (fs_a !== (k == 5)) begin errors++; $display("FAIL midrst_a_fs k=%0d got=%b", k, fs_a); end
    end
  endtask

  task automatic test_div1();
    obs_t ex;
    int pt_ones, rise1, rise2, run, first_run;
    bit prev;
    pt_ones = 0; rise1 = -1; rise2 = -1; run = 0; first_run = -1; prev = 1'b0;
    rst_c = 1'b0;
    repeat (2) @(negedge clk);
    rst_c = 1'b1;
    for (int n = 0; n < 1700; n++) begin
      @(negedge clk);
      ex = model(ec, cc);
      checks++; if (oc !== ex) begin errors++; $display("FAIL div1_c e=%0d got=%h exp=%h", ec, oc, ex); end
      if (ec >= 2 && pt_c) pt_ones++;
      if (hs_c) begin
        run++;
      end else begin
        if (prev && first_run < 0) first_run = run;
        run = 0;
      end
      if (!prev && hs_c) begin
        if (rise1 < 0) rise1 = ec;
        else if (rise2 < 0) rise2 = ec;
      end
      prev = hs_c;
    end
    checks++; if (pt_ones != 1699) begin errors++; $display("FAIL div1_pix_tick got=%0d exp=1699", pt_ones); end
    checks++; if (first_run != 96) begin errors++; $display("FAIL div1_hsync_run got=%0d exp=96", first_run); end
    checks++; if (rise2 - rise1 != 800) begin errors++; $display("FAIL div1_line_period got=%0d exp=800", rise2 - rise1); end
  endtask

  initial begin
    ca = '{d: 4, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
    cb = '{d: 2, ha: 8, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1, pol: 1'b0};
    cc = '{d: 1, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b1};
    test_reset();
    test_line();
    test_frames();
    test_mid_reset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per pixel; legal range 1..16.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0, meaning sync asserted level (0 = active-low).
REQ-005 Port clk, input, 1: the single system clock; all logic runs on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port hsync, output, 1: horizontal sync.
REQ-008 Port vsync, output, 1: vertical sync.
REQ-009 Port active, output, 1: pixel is in the visible area; drives the colour stage's active input.
REQ-010 Port x, output, 10: visible pixel column 0..H_ACTIVE-1, 0 when not active.
REQ-011 Port y, output, 10: visible line 0..V_ACTIVE-1, 0 when not active.
REQ-012 Port pix_tick, output, 1: one-clk pulse marking each new pixel.
REQ-013 Port frame_start, output, 1: one-clk pulse at pixel (0,0) of each frame.

Function
REQ-014 Divider counts 0..CLK_DIV-1 every clk and wraps; the internal tick is high when divider = CLK_DIV-1 (every clk when CLK_DIV = 1).
REQ-015 h_cnt (0..H_TOTAL-1, H_TOTAL = sum of the H parameters = 800) advances only on a tick and wraps to 0 after H_TOTAL-1.
REQ-016 v_cnt (0..V_TOTAL-1, V_TOTAL = 525) advances only on a tick where h_cnt wraps, and wraps to 0 after V_TOTAL-1; a simultaneous h and v wrap gives (0,0).
REQ-017 Decode: active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-018 Decode: hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-019 Decode: vsync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-020 x = h_cnt and y = v_cnt while active, otherwise 0.
REQ-021 All outputs are registered and mutually aligned; each reflects counter state exactly 1 clk after the counter update; outputs hold between ticks.
REQ-022 pix_tick is high on the clk where the outputs present a new pixel; it is high every clk when CLK_DIV = 1.
REQ-023 frame_start is high for exactly one clk, coincident with pix_tick, when the outputs present h_cnt = 0, v_cnt = 0.
REQ-024 Widths: counters are 10 bits; a compile-time check fails if H_TOTAL > 1024 or V_TOTAL > 1024.

Reset
REQ-025 While rst = 0: divider, h_cnt and v_cnt = 0; active = 0; x = y = 0; pix_tick = 0; frame_start = 0; hsync and vsync = !SYNC_POL (deasserted).
REQ-026 Reset asserted mid-frame clears state asynchronously; after release the first tick occurs on the CLK_DIV-th rising edge, and outputs present pixel (0,0) with frame_start = 1 one clk later.

Structure
REQ-027 Timing constants (the H_/V_ defaults, H_TOTAL, V_TOTAL) and the position-width constant belong in shared package vga_pkg, which the colour-pattern stage also imports.
REQ-028 The divider is sub-module vga_pix_tick (clk, rst, tick); the counters and decode stay in vga_timing_gen.

Verification
REQ-029 Hold rst low 10 clks -> hsync = vsync = 1, active = 0, x = y = 0, frame_start = 0 throughout.
REQ-030 Default params, run one line -> hsync low for exactly 96 pix_ticks (384 clks), line period 3200 clks, active high for 640 consecutive pix_ticks with x running 0..639.
REQ-031 Run two full frames -> frame_start period exactly 420000 pix_ticks (1680000 clks), 307200 active pix_ticks per frame, vsync low for exactly 2 lines (1600 pix_ticks).
REQ-032 Assert rst at h_cnt = 300, v_cnt = 200 -> outputs go to reset values immediately; after release, frame_start fires 1 clk after the 4th rising edge.
REQ-033 CLK_DIV = 1, SYNC_POL = 1 -> pix_tick is constantly high after reset; hsync is high for 96 consecutive clks; line period 800 clks.
REQ-034 Check at end of frame: pixel (639,479) followed by the first pixel of the front porch -> active falls, and x and y return to 0 at that pixel.
